// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: requester ids, lock FSM states and
// the response-pipeline entry carried for every granted access.
package bram_arb_pkg;

  typedef enum logic {
    ID_CORE = 1'b0,
    ID_HOST = 1'b1
  } req_id_e;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    we;
  } pipe_entry_t;

endpackage

// File: rtl/bram_rsp_pipe.sv
// Fixed-depth shift register that delays each granted access by the BRAM
// read latency so its response can be routed back to the issuing requester.
module bram_rsp_pipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        flush_i,
  input  pipe_entry_t in_i,
  output pipe_entry_t out_o
);

  pipe_entry_t stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port data BRAM between the core LSU
// and a host requester, with a bounded host lock for read-modify-write.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned R_LATENCY  = 1,
  parameter int unsigned LOCK_MAX   = 16,
  parameter int unsigned HOST_FIRST = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  c_req_i,
  output logic                  c_gnt_o,
  output logic                  c_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic                  c_we_i,
  input  logic [3:0]            c_be_i,
  input  logic [31:0]           c_wdata_i,
  output logic [31:0]           c_rdata_o,
  input  logic                  h_req_i,
  output logic                  h_gnt_o,
  output logic                  h_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic                  h_we_i,
  input  logic [3:0]            h_be_i,
  input  logic [31:0]           h_wdata_i,
  output logic [31:0]           h_rdata_o,
  input  logic                  h_lock_i,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_wdata,
  input  logic [31:0]           bram_rdata
);

  localparam int unsigned      CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  // The pointer names the last winner; the opposite side wins a tie, so
  // HOST_FIRST=1 means the pointer starts on the core.
  localparam req_id_e          PTR_RST  = (HOST_FIRST != 0) ? ID_CORE : ID_HOST;

  lock_state_e      lk_q, lk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_e          ptr_q, ptr_d;
  logic             blk_q, blk_d;

  logic        c_ok;
  pipe_entry_t push, rsp;

  assign c_ok = c_req_i && (lk_q == LK_IDLE);

  always_comb begin
    c_gnt_o = 1'b0;
    h_gnt_o = 1'b0;
    if (!HRESET) begin
      if (c_ok && h_req_i) begin
        if (ptr_q == ID_HOST) c_gnt_o = 1'b1;
        else                  h_gnt_o = 1'b1;
      end else if (c_ok) begin
        c_gnt_o = 1'b1;
      end else if (h_req_i) begin
        h_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    bram_en    = c_gnt_o | h_gnt_o;
    bram_addr  = '0;
    bram_we    = '0;
    bram_wdata = '0;
    if (h_gnt_o) begin
      bram_addr  = h_addr_i;
      bram_we    = h_we_i ? h_be_i : 4'b0000;
      bram_wdata = h_wdata_i;
    end else if (c_gnt_o) begin
      bram_addr  = c_addr_i;
      bram_we    = c_we_i ? c_be_i : 4'b0000;
      bram_wdata = c_wdata_i;
    end
  end

  always_comb begin
    lk_d  = lk_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    blk_d = blk_q;
    if (c_gnt_o)      ptr_d = ID_CORE;
    else if (h_gnt_o) ptr_d = ID_HOST;
    if (c_gnt_o || !c_req_i) blk_d = 1'b0;
    unique case (lk_q)
      LK_IDLE: begin
        if (h_gnt_o && h_lock_i && !blk_q) begin
          lk_d  = LK_LOCKED;
          cnt_d = '0;
        end
      end
      LK_LOCKED: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
        // Timeout hands the next tie to the core and blocks an immediate re-lock.
        if (cnt_q == CNT_LAST) begin
          lk_d  = LK_IDLE;
          ptr_d = ID_HOST;
          blk_d = 1'b1;
        end else if (!h_lock_i && (h_gnt_o || !h_req_i)) begin
          lk_d  = LK_IDLE;
          blk_d = 1'b1;
        end
      end
      default: lk_d = LK_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      lk_q  <= LK_IDLE;
      cnt_q <= '0;
      ptr_q <= PTR_RST;
      blk_q <= 1'b0;
    end else begin
      lk_q  <= lk_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      blk_q <= blk_d;
    end
  end

  always_comb begin
    push.valid = c_gnt_o | h_gnt_o;
    push.id    = h_gnt_o ? ID_HOST : ID_CORE;
    push.we    = h_gnt_o ? h_we_i : c_we_i;
  end

  bram_rsp_pipe #(
    .DEPTH(R_LATENCY)
  ) u_pipe (
    .clk_i  (HCLK),
    .flush_i(HRESET),
    .in_i   (push),
    .out_o  (rsp)
  );

  assign c_rvalid_o = rsp.valid && (rsp.id == ID_CORE) && !HRESET;
  assign h_rvalid_o = rsp.valid && (rsp.id == ID_HOST) && !HRESET;
  assign c_rdata_o  = (c_rvalid_o && !rsp.we) ? bram_rdata : '0;
  assign h_rdata_o  = (h_rvalid_o && !rsp.we) ? bram_rdata : '0;

endmodule
